// File: rtl/vga_timing_pkg.sv
// Shared constants, state encoding and helpers for the VGA timing generator.
package vga_timing_pkg;

  // Default 800x600@72 timing.
  localparam int unsigned DefHActive = 800;
  localparam int unsigned DefHFp     = 56;
  localparam int unsigned DefHSync   = 120;
  localparam int unsigned DefHBp     = 64;
  localparam int unsigned DefVActive = 600;
  localparam int unsigned DefVFp     = 37;
  localparam int unsigned DefVSync   = 6;
  localparam int unsigned DefVBp     = 23;
  localparam int unsigned DefSettle  = 1024;

  // Counter / coordinate width; totals must not exceed 2**CoordW.
  localparam int unsigned CoordW   = 11;
  localparam int unsigned MaxTotal = 2048;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StSettle   = 2'd1,
    StRun      = 2'd2
  } state_e;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/lock_settle.sv
// LOCK synchroniser plus settle FSM; run_en is high while in RUN.
module lock_settle
  import vga_timing_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DefSettle
) (
  input  logic clk,
  input  logic reset,
  input  logic lock,
  output logic run_en,
  output logic lock_ok
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  logic            lock_meta, lock_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchroniser, state and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state_q   <= StWaitLock;
      cnt_q     <= '0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state: any synced low lock sends us back to WAIT_LOCK with the count cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s) state_d = StSettle;
      end
      StSettle: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) state_d = StWaitLock;
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_en  = (state_q == StRun);
  assign lock_ok = lock_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters with registered sync/DE/coordinate decode,
// held blank until PLL lock has settled.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = DefHActive,
  parameter int unsigned H_FP          = DefHFp,
  parameter int unsigned H_SYNC        = DefHSync,
  parameter int unsigned H_BP          = DefHBp,
  parameter int unsigned V_ACTIVE      = DefVActive,
  parameter int unsigned V_FP          = DefVFp,
  parameter int unsigned V_SYNC        = DefVSync,
  parameter int unsigned V_BP          = DefVBp,
  parameter bit          HSYNC_POL     = 1'b1,
  parameter bit          VSYNC_POL     = 1'b1,
  parameter int unsigned SETTLE_CYCLES = DefSettle
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              DE,
  output logic [CoordW-1:0] PIX_X,
  output logic [CoordW-1:0] PIX_Y,
  output logic              LINE_START,
  output logic              FRAME_START,
  output logic              VIDEO_READY
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CoordW-1:0] HLast = CoordW'(H_TOTAL - 1);
  localparam logic [CoordW-1:0] VLast = CoordW'(V_TOTAL - 1);

  if (H_TOTAL > MaxTotal || V_TOTAL > MaxTotal) begin : gen_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end

  logic              run_en, lock_ok;
  logic [CoordW-1:0] h_q, h_d, v_q, v_d;
  logic              de_c, hs_c, vs_c, ls_c;

  lock_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_lock_settle (
    .clk    (CLK),
    .reset  (RESET),
    .lock   (LOCK),
    .run_en (run_en),
    .lock_ok(lock_ok)
  );

  // Counters advance only in RUN and clear on the same edge that leaves RUN.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_en && lock_ok) begin
      h_d = (h_q == HLast) ? '0 : h_q + 1'b1;
      v_d = v_q;
      if (h_q == HLast) v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end
  end

  // Decode from the current counters; everything inactive outside RUN.
  always_comb begin
    de_c = run_en && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_c = run_en && (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_c = run_en && (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    ls_c = de_c && (h_q == '0);
  end

  // Counter registers and one-cycle-delayed output decode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q         <= '0;
      v_q         <= '0;
      HSYNC       <= ~HSYNC_POL;
      VSYNC       <= ~VSYNC_POL;
      DE          <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      HSYNC       <= HSYNC_POL ? hs_c : ~hs_c;
      VSYNC       <= VSYNC_POL ? vs_c : ~vs_c;
      DE          <= de_c;
      PIX_X       <= de_c ? h_q : '0;
      PIX_Y       <= de_c ? v_q : '0;
      LINE_START  <= ls_c;
      FRAME_START <= ls_c && (v_q == '0);
    end
  end

  assign VIDEO_READY = run_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x8 raster, with an
// active-low-sync twin instance sharing the same stimulus.
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;  // H_TOTAL 15
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;  // V_TOTAL 8
  localparam int unsigned HT = 15, VT = 8, ST = 16;

  logic clk = 1'b0, reset = 1'b1, lock = 1'b1;
  logic hs_a, vs_a, de_a, ls_a, fs_a, vr_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b, vr_b;
  logic [10:0] x_a, y_a, x_b, y_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SETTLE_CYCLES(ST)
  ) u_dut (
    .CLK(clk), .RESET(reset), .LOCK(lock), .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a),
    .PIX_X(x_a), .PIX_Y(y_a), .LINE_START(ls_a), .FRAME_START(fs_a), .VIDEO_READY(vr_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SETTLE_CYCLES(ST)
  ) u_dut_neg (
    .CLK(clk), .RESET(reset), .LOCK(lock), .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b),
    .PIX_X(x_b), .PIX_Y(y_b), .LINE_START(ls_b), .FRAME_START(fs_b), .VIDEO_READY(vr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Positive instance packed as {HS,VS,DE,LS,FS,VR,X,Y}.
  function automatic logic [31:0] pack_a();
    return {4'b0, hs_a, vs_a, de_a, ls_a, fs_a, vr_a, x_a, y_a};
  endfunction

  function automatic logic [31:0] exp_pack(input logic hs, input logic vs, input logic de,
                                           input logic ls, input logic fs, input logic vr,
                                           input int unsigned x, input int unsigned y);
    return {4'b0, hs, vs, de, ls, fs, vr, 11'(x), 11'(y)};
  endfunction

  initial begin
    int unsigned eh, ev, hs_n, vs_n, de_n, fs_first, fs_second, fs_seen, ls_at, hs_off;
    logic e_hs, e_vs, e_de, e_ls, e_fs, hs_prev;

    // 1: reset held with LOCK high.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_a", pack_a(), exp_pack(0, 0, 0, 0, 0, 0, 0, 0));
      chk("reset_neg_sync", {30'b0, hs_b, vs_b}, 32'd3);
    end
    reset = 1'b0;

    // 2: settle after release; RUN on the 19th edge, first frame pixel on the 20th.
    for (int k = 1; k <= 18; k++) tick();
    chk("settle_not_ready", pack_a(), exp_pack(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("run_entry", pack_a(), exp_pack(0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    chk("first_pixel", pack_a(), exp_pack(0, 0, 1, 1, 1, 1, 0, 0));

    // 3: two free-running frames against a raster model.
    eh = 0; ev = 0; hs_n = 0; vs_n = 0; de_n = 0; fs_seen = 0;
    fs_first = 0; fs_second = 0; ls_at = 0; hs_off = 0; hs_prev = 1'b0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      e_de = (eh < HA) && (ev < VA);
      e_hs = (eh >= HA + HF) && (eh < HA + HF + HS);
      e_vs = (ev >= VA + VF) && (ev < VA + VF + VS);
      e_ls = e_de && (eh == 0);
      e_fs = e_ls && (ev == 0);
      chk("raster", pack_a(), exp_pack(e_hs, e_vs, e_de, e_ls, e_fs, 1, e_de ? eh : 0,
                                      e_de ? ev : 0));
      chk("raster_neg_sync", {30'b0, hs_b, vs_b}, {30'b0, ~e_hs, ~e_vs});
      if (ls_a) ls_at = n;
      if (hs_a && !hs_prev && n == 10) hs_off = n - ls_at;
      if (fs_a) begin
        if (fs_seen == 0) fs_first = n;
        else fs_second = n;
        fs_seen++;
      end
      hs_prev = hs_a;
      hs_n += hs_a;
      vs_n += vs_a;
      de_n += de_a;
      tick();
      eh = (eh == HT - 1) ? 0 : eh + 1;
      if (eh == 0) ev = (ev == VT - 1) ? 0 : ev + 1;
    end
    chk("hsync_high_clks", hs_n, 2 * VT * HS);
    chk("vsync_high_clks", vs_n, 2 * VS * HT);
    chk("de_high_clks", de_n, 2 * VA * HA);
    chk("hsync_offset", hs_off, HA + HF);
    chk("frame_period", fs_second - fs_first, HT * VT);

    // 4: fresh reset with LOCK low, then a one-clock LOCK glitch during SETTLE.
    reset = 1'b1;
    lock  = 1'b0;
    tick();
    tick();
    chk("reset2", pack_a(), exp_pack(0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick();
    tick();
    chk("wait_lock_idle", pack_a(), exp_pack(0, 0, 0, 0, 0, 0, 0, 0));
    lock = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 11) lock = 1'b0;
      if (k == 12) lock = 1'b1;
      if (k == 19) chk("glitch_no_early_run", vr_a, 1'b0);
      if (k == 30) chk("glitch_not_ready", vr_a, 1'b0);
      if (k == 31) chk("glitch_ready", vr_a, 1'b1);
    end

    // 5: lose lock at PIX_X=4, then relock into a fresh frame.
    tick();
    chk("relock_frame", pack_a(), exp_pack(0, 0, 1, 1, 1, 1, 0, 0));
    for (int k = 1; k <= 4; k++) tick();
    chk("x4", pack_a(), exp_pack(0, 0, 1, 0, 0, 1, 4, 0));
    lock = 1'b0;
    tick();
    chk("drop_x5", pack_a(), exp_pack(0, 0, 1, 0, 0, 1, 5, 0));
    tick();
    chk("drop_x6", pack_a(), exp_pack(0, 0, 1, 0, 0, 1, 6, 0));
    tick();
    chk("drop_x7", pack_a(), exp_pack(0, 0, 1, 0, 0, 0, 7, 0));
    tick();
    chk("drop_blank", pack_a(), exp_pack(0, 0, 0, 0, 0, 0, 0, 0));
    chk("drop_blank_neg", {30'b0, hs_b, vs_b}, 32'd3);
    lock = 1'b1;
    for (int k = 1; k <= 18; k++) tick();
    chk("relock_not_ready", vr_a, 1'b0);
    tick();
    chk("relock_run", pack_a(), exp_pack(0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    chk("relock_origin", pack_a(), exp_pack(0, 0, 1, 1, 1, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
